// File: rtl/output_port_tx.sv
// output_port_tx: transmit end of a leaf-interface link.
// Packs user words into BFT packets addressed to a remote input-port buffer of
// DEPTH = 2**NUM_ADDR_BITS slots. A credit counter tracks free remote slots; it
// is replenished by freespace-update packets that target this port.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   din_user / vld_user2interface / ack_interface2user   user stream (vld & ack)
//   dst_leaf, dst_port      destination, sampled when a word is loaded
//   packet_from_output_port packet to BFT, MSB is valid
//   ack_bft2interface       BFT accepted the presented packet
//   credit_pkt              incoming freespace-update packet
//   credit_err              sticky credit overflow flag
module output_port_tx #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int PORT_No               = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  output logic [PACKET_BITS-1:0]   packet_from_output_port,
  input  logic                     ack_bft2interface,
  input  logic [PACKET_BITS-1:0]   credit_pkt,
  output logic                     credit_err
);
  localparam int DEPTH    = 1 << NUM_ADDR_BITS;
  localparam int PAD      = PACKET_BITS-1-NUM_LEAF_BITS-NUM_PORT_BITS-NUM_ADDR_BITS-PAYLOAD_BITS;
  localparam int PORT_LSB = PACKET_BITS-1-NUM_LEAF_BITS-NUM_PORT_BITS;
  localparam logic [NUM_ADDR_BITS:0] DEPTH_C = (NUM_ADDR_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

  state_t                   state_q, state_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_ADDR_BITS:0]   credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0] wraddr_q, wraddr_d;
  logic                     err_q, err_d;

  // 2-entry skid FIFO
  logic [1:0][PAYLOAD_BITS-1:0] mem_q;
  logic                         rd_ptr_q, wr_ptr_q;
  logic [1:0]                   cnt_q;
  logic                         empty, full, push_req, have_word, pop, fifo_wr, fifo_rd;
  logic [PAYLOAD_BITS-1:0]      head;

  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign push_req  = vld_user2interface & ~full;
  // With the FIFO empty, an arriving word bypasses storage so it can be
  // presented the very next cycle.
  assign head      = empty ? din_user : mem_q[rd_ptr_q];
  assign have_word = ~empty | push_req;
  assign fifo_wr   = push_req & ~(pop & empty);
  assign fifo_rd   = pop & ~empty;

  assign ack_interface2user      = ~full;
  assign packet_from_output_port = pkt_q;
  assign credit_err              = err_q;

  // Credits: handshake decrement and update increment resolved together
  logic        hs, credit_in, ovf, avail;
  logic [31:0] sum;

  assign hs        = pkt_q[PACKET_BITS-1] & ack_bft2interface;
  assign credit_in = credit_pkt[PACKET_BITS-1] &
                     (credit_pkt[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(PORT_No));

  always_comb begin
    sum       = 32'(credits_q) - 32'(hs) + (credit_in ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0);
    ovf       = (sum > 32'(DEPTH));
    credits_d = ovf ? DEPTH_C : (NUM_ADDR_BITS+1)'(sum);
    err_d     = err_q | ovf;
    wraddr_d  = wraddr_q + NUM_ADDR_BITS'(hs);
  end

  // Load decisions look at next-cycle credits so a same-cycle update can
  // keep the stream going when the counter would otherwise hit zero.
  assign avail = (credits_d != '0);

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, STALL: begin
        if (have_word && avail) pop = 1'b1;
        else if (have_word)     state_d = STALL;
        else                    state_d = IDLE;
      end
      SEND: begin
        if (hs) begin
          if (have_word && avail) pop = 1'b1;
          else begin
            pkt_d   = '0;
            state_d = have_word ? STALL : IDLE;
          end
        end
      end
      default: begin
        pkt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      pkt_d   = {1'b1, dst_leaf, dst_port, {PAD{1'b0}}, wraddr_d, head};
      state_d = SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      credits_q <= DEPTH_C;
      wraddr_q  <= '0;
      err_q     <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      credits_q <= credits_d;
      wraddr_q  <= wraddr_d;
      err_q     <= err_d;
      if (fifo_wr) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_rd) rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_q + 2'(fifo_wr) - 2'(fifo_rd);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= din_user;
  end

  logic unused_credit_bits;
  assign unused_credit_bits = ^{credit_pkt[PACKET_BITS-2:PORT_LSB+NUM_PORT_BITS],
                                credit_pkt[PORT_LSB-1:0]};
endmodule
